rc4_phase_sequencer: RTL

Top-level controller for the RC4 datapath. Runs the three RC4 tasks in fixed order: S-init (s[i]=i), key-schedule shuffle, then decrypt. Each task gets a one-cycle start pulse, and the sequencer waits for that task's finish pulse. The sequencer owns the single-port S memory and grants its address/data/write bus to exactly one task at a time. It also latches the 24-bit key so the key stays stable for all tasks.

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/rc4_mem_mux.sv | 28 ++
 rtl/rc4_phase_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 sequencer and its S-memory grant mux.
package rc4_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned KEY_W   = 24;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned CNT_W   = 16;

  localparam logic [PHASE_W-1:0] PH_INIT    = 2'd0;
  localparam logic [PHASE_W-1:0] PH_SHUFFLE = 2'd1;
  localparam logic [PHASE_W-1:0] PH_DECRYPT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
  } mem_req_t;

endpackage

// File: rtl/rc4_mem_mux.sv
// Combinational S-memory grant: forwards the selected task's bus when enabled, else drives zero.
module rc4_mem_mux
  import rc4_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 3
) (
  input  logic                         en,
  input  logic [PHASE_W-1:0]           sel,
  input  logic [NUM_PHASES*ADDR_W-1:0] addr,
  input  logic [NUM_PHASES*DATA_W-1:0] wrdata,
  input  logic [NUM_PHASES-1:0]        wren,
  output mem_req_t                     req
);

  always_comb begin
    req = '0;
    if (en) begin
      for (int k = 0; k < NUM_PHASES; k++) begin
        if (sel == PHASE_W'(k)) begin
          req.addr   = addr[k*ADDR_W +: ADDR_W];
          req.wrdata = wrdata[k*DATA_W +: DATA_W];
          req.wren   = wren[k];
        end
      end
    end
  end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Runs S-init, key shuffle and decrypt in order, handing the single-port S memory
// to whichever task is currently waited on.
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 3,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         go,
  input  logic                         abort,
  input  logic [KEY_W-1:0]             key_in,
  output logic [KEY_W-1:0]             key_out,
  output logic [NUM_PHASES-1:0]        cl_start,
  input  logic [NUM_PHASES-1:0]        cl_finish,
  input  logic [NUM_PHASES*ADDR_W-1:0] cl_addr,
  input  logic [NUM_PHASES*DATA_W-1:0] cl_wrdata,
  input  logic [NUM_PHASES-1:0]        cl_wren,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wrdata,
  output logic                         s_wren,
  output logic [PHASE_W-1:0]           phase,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam bit                 TO_EN      = (TIMEOUT != 0);

  state_e                  state, state_d;
  logic [PHASE_W-1:0]      phase_d;
  logic [KEY_W-1:0]        key_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [NUM_PHASES-1:0]   cl_start_d;
  logic                    busy_d, done_d, err_d;
  logic                    fin_cur;
  mem_req_t                req;

  assign fin_cur = cl_finish[phase];

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      phase    <= PH_INIT;
      key_out  <= '0;
      cnt      <= '0;
      cl_start <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      key_out  <= key_d;
      cnt      <= cnt_d;
      cl_start <= cl_start_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Next state plus phase/key/timeout-counter updates; abort overrides everything
  always_comb begin
    state_d = state;
    phase_d = phase;
    key_d   = key_out;
    cnt_d   = cnt;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state_d = ST_START;
            phase_d = PH_INIT;
            key_d   = key_in;
          end
        end
        ST_START: begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (fin_cur) begin
            state_d = ST_NEXT;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          if (phase == LAST_PHASE) begin
            state_d = ST_DONE;
          end else begin
            phase_d = phase + PHASE_W'(1);
            state_d = ST_START;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    cl_start_d = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err;
    if ((state == ST_IDLE) && (state_d == ST_START)) err_d = 1'b0;
    case (state_d)
      ST_START: begin
        cl_start_d = NUM_PHASES'(1) << phase_d;
        busy_d     = 1'b1;
      end
      ST_WAIT, ST_NEXT: busy_d = 1'b1;
      ST_DONE:          done_d = 1'b1;
      ST_ERR:           err_d  = 1'b1;
      default: ;
    endcase
  end

  rc4_mem_mux #(
    .NUM_PHASES (NUM_PHASES)
  ) u_mem_mux (
    .en     (state == ST_WAIT),
    .sel    (phase),
    .addr   (cl_addr),
    .wrdata (cl_wrdata),
    .wren   (cl_wren),
    .req    (req)
  );

  assign s_addr   = req.addr;
  assign s_wrdata = req.wrdata;
  assign s_wren   = req.wren;

endmodule
